// File: rtl/car_detector_pkg.sv
// Shared types for the lot-gate car detector: FSM state encoding and the
// debounced beam patterns {deb_a, deb_b} that drive it.
package car_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ENT_A    = 3'd1,
        ENT_AB   = 3'd2,
        ENT_B    = 3'd3,
        EXT_B    = 3'd4,
        EXT_AB   = 3'd5,
        EXT_A    = 3'd6,
        WAIT_CLR = 3'd7
    } car_state_t;

    localparam logic [1:0] PAT_CLR = 2'b00;
    localparam logic [1:0] PAT_A   = 2'b10;
    localparam logic [1:0] PAT_B   = 2'b01;
    localparam logic [1:0] PAT_AB  = 2'b11;

endpackage

// File: rtl/car_detector_sensor_debounce.sv
// Two-flop synchroniser followed by a consecutive-mismatch debouncer for one
// photo-beam input; the output only moves after DB_CYCLES stable samples.
module sensor_debounce #(
    parameter int DB_CYCLES = 16,
    parameter int DB_W      = $clog2(DB_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic deb
);

    logic            sync1_q, sync1_d;
    logic            sync2_q, sync2_d;
    logic            deb_q,   deb_d;
    logic [DB_W-1:0] cnt_q,   cnt_d;

    always_comb begin
        sync1_d = raw;
        sync2_d = sync1_q;
        deb_d   = deb_q;
        cnt_d   = '0;
        // Any matching sample restarts the run, so short glitches never flip deb.
        if (sync2_q != deb_q) begin
            if (cnt_q == DB_W'(DB_CYCLES - 1)) begin
                deb_d = ~deb_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            deb_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            deb_q   <= deb_d;
            cnt_q   <= cnt_d;
        end
    end

    assign deb = deb_q;

endmodule

// File: rtl/car_detector.sv
// Lot-gate passage recogniser: debounces both beams and walks an entry/exit
// FSM, emitting registered one-cycle inc/dec/seq_err pulses.
module car_detector
    import car_pkg::*;
#(
    parameter int DB_CYCLES = 16,
    parameter int DB_W      = $clog2(DB_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic sensor_a,
    input  logic sensor_b,
    output logic inc,
    output logic dec,
    output logic seq_err,
    output logic busy
);

    logic       deb_a, deb_b;
    logic [1:0] pat;

    car_state_t state_q, state_d;
    logic       inc_q, inc_d;
    logic       dec_q, dec_d;
    logic       seq_err_q, seq_err_d;

    sensor_debounce #(.DB_CYCLES(DB_CYCLES), .DB_W(DB_W)) u_deb_a (
        .clk (clk),
        .rst (rst),
        .raw (sensor_a),
        .deb (deb_a)
    );

    sensor_debounce #(.DB_CYCLES(DB_CYCLES), .DB_W(DB_W)) u_deb_b (
        .clk (clk),
        .rst (rst),
        .raw (sensor_b),
        .deb (deb_b)
    );

    assign pat = {deb_a, deb_b};

    always_comb begin
        state_d   = state_q;
        inc_d     = 1'b0;
        dec_d     = 1'b0;
        seq_err_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                case (pat)
                    PAT_A:   state_d = ENT_A;
                    PAT_B:   state_d = EXT_B;
                    PAT_AB:  seq_err_d = 1'b1;
                    default: ;
                endcase
            end
            ENT_A: begin
                case (pat)
                    PAT_AB:  state_d = ENT_AB;
                    PAT_CLR: state_d = IDLE;
                    PAT_B:   seq_err_d = 1'b1;
                    default: ;
                endcase
            end
            ENT_AB: begin
                case (pat)
                    PAT_B:   state_d = ENT_B;
                    PAT_A:   state_d = ENT_A;
                    PAT_CLR: seq_err_d = 1'b1;
                    default: ;
                endcase
            end
            ENT_B: begin
                case (pat)
                    PAT_CLR: begin
                        state_d = IDLE;
                        inc_d   = 1'b1;
                    end
                    PAT_AB:  state_d = ENT_AB;
                    PAT_A:   seq_err_d = 1'b1;
                    default: ;
                endcase
            end
            EXT_B: begin
                case (pat)
                    PAT_AB:  state_d = EXT_AB;
                    PAT_CLR: state_d = IDLE;
                    PAT_A:   seq_err_d = 1'b1;
                    default: ;
                endcase
            end
            EXT_AB: begin
                case (pat)
                    PAT_A:   state_d = EXT_A;
                    PAT_B:   state_d = EXT_B;
                    PAT_CLR: seq_err_d = 1'b1;
                    default: ;
                endcase
            end
            EXT_A: begin
                case (pat)
                    PAT_CLR: begin
                        state_d = IDLE;
                        dec_d   = 1'b1;
                    end
                    PAT_AB:  state_d = EXT_AB;
                    PAT_B:   seq_err_d = 1'b1;
                    default: ;
                endcase
            end
            WAIT_CLR: begin
                if (pat == PAT_CLR) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // An errored passage parks in WAIT_CLR until both beams clear.
        if (seq_err_d) begin
            state_d = (pat == PAT_CLR) ? IDLE : WAIT_CLR;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            inc_q     <= 1'b0;
            dec_q     <= 1'b0;
            seq_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            inc_q     <= inc_d;
            dec_q     <= dec_d;
            seq_err_q <= seq_err_d;
        end
    end

    assign inc     = inc_q;
    assign dec     = dec_q;
    assign seq_err = seq_err_q;
    assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_car_detector.sv
// Directed-vector bench for car_detector with a pulse scoreboard: stimulus
// queues the expected pulse and its cycle, a monitor pops on every pulse.
module tb_car_detector;

    localparam int DB  = 4;
    localparam int LAT = DB + 3;

    localparam logic [2:0] K_NONE = 3'b000;
    localparam logic [2:0] K_INC  = 3'b100;
    localparam logic [2:0] K_DEC  = 3'b010;
    localparam logic [2:0] K_ERR  = 3'b001;

    typedef struct {
        logic [2:0] kind;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic sensor_a, sensor_b;
    logic inc, dec, seq_err, busy;

    int   cyc = 0;
    int   compared = 0;
    int   mismatched = 0;
    exp_t sb_q[$];

    car_detector #(.DB_CYCLES(DB)) dut (
        .clk      (clk),
        .rst      (rst),
        .sensor_a (sensor_a),
        .sensor_b (sensor_b),
        .inc      (inc),
        .dec      (dec),
        .seq_err  (seq_err),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        compared++;
        if (act != req) begin
            mismatched++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every pulse must match the oldest queued expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst === 1'b1 && (inc | dec | seq_err)) begin
            if (sb_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_pulse actual={inc,dec,err}=%b required=none (cycle %0d)",
                         {inc, dec, seq_err}, cyc);
            end else begin
                e = sb_q.pop_front();
                check("pulse_kind", int'({inc, dec, seq_err}), int'(e.kind));
                check("pulse_cycle", cyc, e.cyc);
            end
        end
    end

    // Drive pattern {a,b} for 'hold' edges; an expected pulse lands LAT edges
    // after the drive point (sync 2 + debounce DB + FSM register 1).
    task automatic drive(input logic [1:0] p, input int hold, input logic [2:0] kind);
        @(negedge clk);
        {sensor_a, sensor_b} = p;
        if (kind != K_NONE) sb_q.push_back('{kind: kind, cyc: cyc + LAT});
        repeat (hold) @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        rst      = 1'b0;
        sensor_a = 1'b0;
        sensor_b = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_inc", int'(inc), 0);
        check("rst_dec", int'(dec), 0);
        check("rst_err", int'(seq_err), 0);
        check("rst_busy", int'(busy), 0);
        @(negedge clk);
        rst = 1'b1;
        drive(2'b00, 10, K_NONE);

        // Entry
        drive(2'b10, 10, K_NONE);
        check("entry_busy_enta", int'(busy), 1);
        drive(2'b11, 10, K_NONE);
        drive(2'b01, 10, K_NONE);
        check("entry_busy_entb", int'(busy), 1);
        drive(2'b00, 10, K_INC);
        check("entry_busy_end", int'(busy), 0);

        // Exit
        drive(2'b01, 10, K_NONE);
        check("exit_busy_extb", int'(busy), 1);
        drive(2'b11, 10, K_NONE);
        drive(2'b10, 10, K_NONE);
        drive(2'b00, 10, K_DEC);
        check("exit_busy_end", int'(busy), 0);

        // Back-outs on both sides
        drive(2'b10, 10, K_NONE);
        drive(2'b11, 10, K_NONE);
        drive(2'b10, 10, K_NONE);
        drive(2'b00, 10, K_NONE);
        check("backout_ent_busy", int'(busy), 0);
        drive(2'b01, 10, K_NONE);
        drive(2'b00, 10, K_NONE);
        check("backout_ext_busy", int'(busy), 0);

        // Glitch shorter than DB is invisible; DB+1 cycles is seen
        drive(2'b10, 3, K_NONE);
        drive(2'b00, 10, K_NONE);
        check("glitch3_busy", int'(busy), 0);
        drive(2'b10, 5, K_NONE);
        drive(2'b00, 3, K_NONE);
        check("glitch5_busy_rise", int'(busy), 1);
        repeat (7) @(posedge clk);
        #1;
        check("glitch5_busy_end", int'(busy), 0);

        // Illegal A -> B swap in one step
        drive(2'b10, 10, K_NONE);
        drive(2'b01, 10, K_ERR);
        check("illegal_busy_wait", int'(busy), 1);
        drive(2'b01, 10, K_NONE);
        check("illegal_busy_hold", int'(busy), 1);
        drive(2'b00, 10, K_NONE);
        check("illegal_busy_end", int'(busy), 0);

        // Reset in the middle of an entry
        drive(2'b10, 10, K_NONE);
        drive(2'b11, 10, K_NONE);
        check("midrst_busy_entab", int'(busy), 1);
        @(negedge clk);
        rst      = 1'b0;
        sensor_a = 1'b0;
        sensor_b = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            check("midrst_inc", int'(inc), 0);
            check("midrst_dec", int'(dec), 0);
            check("midrst_err", int'(seq_err), 0);
            check("midrst_busy", int'(busy), 0);
        end
        @(negedge clk);
        rst = 1'b1;
        drive(2'b00, 10, K_NONE);
        check("postrst_busy", int'(busy), 0);
        drive(2'b10, 10, K_NONE);
        drive(2'b11, 10, K_NONE);
        drive(2'b01, 10, K_NONE);
        drive(2'b00, 10, K_INC);
        check("postrst_entry_busy", int'(busy), 0);

        repeat (5) @(negedge clk);
        check("scoreboard_drained", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
